// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt dispatch stage.
// Holds the FSM state encoding, level codes and the level-flag encoder.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    CLR    = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam logic [1:0] LVL_A = 2'd0;
  localparam logic [1:0] LVL_B = 2'd1;
  localparam logic [1:0] LVL_C = 2'd2;

  localparam int NUM_LEVELS = 3;
  localparam int NUM_CHAN   = 9;

  // Any=1 with no flag set still resolves to the lowest level.
  function automatic logic [1:0] lvl_encode(input logic [2:0] flags);
    if (flags[0])      return LVL_A;
    else if (flags[1]) return LVL_B;
    else               return LVL_C;
  endfunction

endpackage

// File: rtl/irq_cycle_timer.sv
// Loadable down-counter with zero flag; load has priority over decrement.
// Counts down one per cycle and parks at zero.
module irq_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/irq_dispatch_seq.sv
// Registers the priority-encoder result and runs the irq/ack/clear handshake toward the CPU.
// Optional per-level service counters are built when IRQ_DISPATCH_STATS_EN is defined.
module irq_dispatch_seq
  import irq_pkg::*;
#(
  parameter int CHAN_W  = 4,
  parameter int HOLDOFF = 2,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe_any_i,
  input  logic [2:0]        pe_level_i,
  input  logic [CHAN_W-1:0] pe_chan_i,
  output logic              irq_o,
  output logic [1:0]        irq_level_o,
  output logic [CHAN_W-1:0] irq_chan_o,
  input  logic              irq_ack_i,
  output logic              clr_valid_o,
  output logic [1:0]        clr_level_o,
  output logic [CHAN_W-1:0] clr_chan_o,
  output logic              busy_o,
  output logic              timeout_err_o,
  input  logic              timeout_clr_i
`ifdef IRQ_DISPATCH_STATS_EN
  ,
  output logic [3*CNT_W-1:0] svc_cnt_o
`endif
);

  localparam int TMR_MAX = (HOLDOFF > TIMEOUT) ? HOLDOFF : TIMEOUT;
  localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;
  // Loaded with N-1 so that exactly N cycles are spent in the timed state.
  localparam logic [TMR_W-1:0] TO_LOAD = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
  localparam logic [TMR_W-1:0] HO_LOAD = (HOLDOFF > 0) ? TMR_W'(HOLDOFF - 1) : '0;

  state_e            state_q, state_d;
  logic              any_in_q, any_in_d;
  logic [2:0]        lvl_in_q, lvl_in_d;
  logic [CHAN_W-1:0] chan_in_q, chan_in_d;
  logic [1:0]        lvl_q, lvl_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic              err_q, err_d;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;
  logic              to_evt;

  irq_cycle_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    to_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_in_q) begin
          state_d  = REQ;
          tmr_load = 1'b1;
          tmr_val  = TO_LOAD;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d = CLR;
        end else if (TIMEOUT != 0 && tmr_zero) begin
          to_evt   = 1'b1;
          state_d  = (HOLDOFF == 0) ? IDLE : SETTLE;
          tmr_load = 1'b1;
          tmr_val  = HO_LOAD;
        end
      end
      CLR: begin
        state_d  = (HOLDOFF == 0) ? IDLE : SETTLE;
        tmr_load = 1'b1;
        tmr_val  = HO_LOAD;
      end
      SETTLE: begin
        if (tmr_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    any_in_d  = pe_any_i;
    lvl_in_d  = pe_level_i;
    chan_in_d = pe_chan_i;
    lvl_d     = lvl_q;
    chan_d    = chan_q;
    if (state_q == IDLE && any_in_q) begin
      lvl_d  = lvl_encode(lvl_in_q);
      chan_d = chan_in_q;
    end
    err_d = err_q;
    if (timeout_clr_i) err_d = 1'b0;
    if (to_evt)        err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      any_in_q  <= 1'b0;
      lvl_in_q  <= '0;
      chan_in_q <= '0;
      lvl_q     <= '0;
      chan_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      any_in_q  <= any_in_d;
      lvl_in_q  <= lvl_in_d;
      chan_in_q <= chan_in_d;
      lvl_q     <= lvl_d;
      chan_q    <= chan_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    irq_o         = (state_q == REQ);
    irq_level_o   = lvl_q;
    irq_chan_o    = chan_q;
    clr_valid_o   = (state_q == CLR);
    clr_level_o   = clr_valid_o ? lvl_q  : '0;
    clr_chan_o    = clr_valid_o ? chan_q : '0;
    busy_o        = (state_q != IDLE);
    timeout_err_o = err_q;
  end

`ifdef IRQ_DISPATCH_STATS_EN
  logic [NUM_LEVELS-1:0][CNT_W-1:0] svc_q, svc_d;

  always_comb begin
    svc_d = svc_q;
    if (state_q == REQ && state_d == CLR) begin
      for (int i = 0; i < NUM_LEVELS; i++) begin
        if (lvl_q == 2'(i) && svc_q[i] != '1)
          svc_d[i] = svc_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) svc_q <= '0;
    else     svc_q <= svc_d;
  end

  assign svc_cnt_o = svc_q;
`endif

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// Directed bench for irq_dispatch_seq; cycle 0 is the cycle in which the encoder output is presented.
// Build with IRQ_DISPATCH_STATS_EN to also exercise the saturating service counters.
module tb_irq_dispatch_seq;

`ifdef IRQ_DISPATCH_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif
  localparam int CHAN_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pe_any_i;
  logic [2:0]        pe_level_i;
  logic [CHAN_W-1:0] pe_chan_i;
  logic              irq_o;
  logic [1:0]        irq_level_o;
  logic [CHAN_W-1:0] irq_chan_o;
  logic              irq_ack_i;
  logic              clr_valid_o;
  logic [1:0]        clr_level_o;
  logic [CHAN_W-1:0] clr_chan_o;
  logic              busy_o;
  logic              timeout_err_o;
  logic              timeout_clr_i;
`ifdef IRQ_DISPATCH_STATS_EN
  logic [3*CNT_W-1:0] svc_cnt_o;
`endif

  irq_dispatch_seq #(
    .CHAN_W (CHAN_W),
    .HOLDOFF(2),
    .TIMEOUT(8),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pe_any_i     (pe_any_i),
    .pe_level_i   (pe_level_i),
    .pe_chan_i    (pe_chan_i),
    .irq_o        (irq_o),
    .irq_level_o  (irq_level_o),
    .irq_chan_o   (irq_chan_o),
    .irq_ack_i    (irq_ack_i),
    .clr_valid_o  (clr_valid_o),
    .clr_level_o  (clr_level_o),
    .clr_chan_o   (clr_chan_o),
    .busy_o       (busy_o),
    .timeout_err_o(timeout_err_o),
    .timeout_clr_i(timeout_clr_i)
`ifdef IRQ_DISPATCH_STATS_EN
    ,
    .svc_cnt_o    (svc_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int clr_cnt = 0;
  int snap;

  always @(negedge clk) if (clr_valid_o) clr_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic any, input logic [2:0] lvl, input logic [CHAN_W-1:0] chan);
    pe_any_i   = any;
    pe_level_i = lvl;
    pe_chan_i  = chan;
  endtask

  // Drops the request, acks whatever is raised and waits for the FSM to return to IDLE.
  task automatic go_idle();
    present(1'b0, 3'b000, '0);
    for (int i = 0; i < 40; i++) begin
      irq_ack_i = irq_o;
      step();
      if (i > 2 && !busy_o && !irq_o) break;
    end
    irq_ack_i = 1'b0;
    chk("idle_wait", {31'd0, busy_o}, 32'd0);
    timeout_clr_i = 1'b1;
    step();
    timeout_clr_i = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    irq_ack_i = 1'b0;
    timeout_clr_i = 1'b0;
    present(1'b0, 3'b000, '0);
    step(); step(); step();
    chk("rst_irq",   {31'd0, irq_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_clr",   {31'd0, clr_valid_o}, 32'd0);
    chk("rst_err",   {31'd0, timeout_err_o}, 32'd0);
    chk("rst_chan",  {28'd0, irq_chan_o}, 32'd0);
    chk("rst_level", {30'd0, irq_level_o}, 32'd0);
    rst = 1'b0;
    step();

    // Basic service: request at c0, ack at c4.
    present(1'b1, 3'b010, 4'd5);
    step();                                            // c1
    chk("bas_c1_irq", {31'd0, irq_o}, 32'd0);
    step();                                            // c2
    chk("bas_c2_irq",  {31'd0, irq_o}, 32'd1);
    chk("bas_c2_lvl",  {30'd0, irq_level_o}, 32'd1);
    chk("bas_c2_chan", {28'd0, irq_chan_o}, 32'd5);
    chk("bas_c2_busy", {31'd0, busy_o}, 32'd1);
    step();                                            // c3
    present(1'b0, 3'b000, '0);
    chk("bas_c3_irq", {31'd0, irq_o}, 32'd1);
    step();                                            // c4
    chk("bas_c4_irq", {31'd0, irq_o}, 32'd1);
    irq_ack_i = 1'b1;
    step();                                            // c5
    irq_ack_i = 1'b0;
    chk("bas_c5_irq",  {31'd0, irq_o}, 32'd0);
    chk("bas_c5_clr",  {31'd0, clr_valid_o}, 32'd1);
    chk("bas_c5_clvl", {30'd0, clr_level_o}, 32'd1);
    chk("bas_c5_cch",  {28'd0, clr_chan_o}, 32'd5);
    step();                                            // c6
    chk("bas_c6_clr",  {31'd0, clr_valid_o}, 32'd0);
    chk("bas_c6_busy", {31'd0, busy_o}, 32'd1);
    step();                                            // c7
    chk("bas_c7_busy", {31'd0, busy_o}, 32'd1);
    step();                                            // c8
    chk("bas_c8_busy", {31'd0, busy_o}, 32'd0);
    go_idle();

    // Level decode: all flags -> A; any with no flags -> C.
    present(1'b1, 3'b111, 4'd2);
    step(); step();
    chk("dec_all_lvl",  {30'd0, irq_level_o}, 32'd0);
    chk("dec_all_chan", {28'd0, irq_chan_o}, 32'd2);
    go_idle();
    present(1'b1, 3'b000, 4'd8);
    step(); step();
    chk("dec_none_lvl",  {30'd0, irq_level_o}, 32'd2);
    chk("dec_none_chan", {28'd0, irq_chan_o}, 32'd8);
    go_idle();

    // Timeout: request held with no ack.
    present(1'b1, 3'b100, 4'd3);
    snap = clr_cnt;
    step();                                            // c1
    chk("to_c1_irq", {31'd0, irq_o}, 32'd0);
    for (int c = 2; c <= 9; c++) begin
      step();
      chk("to_irq_hi", {31'd0, irq_o}, 32'd1);
    end
    step();                                            // c10
    chk("to_c10_irq", {31'd0, irq_o}, 32'd0);
    chk("to_c10_err", {31'd0, timeout_err_o}, 32'd1);
    chk("to_c10_clr", {31'd0, clr_valid_o}, 32'd0);
    step();                                            // c11
    chk("to_no_clr_pulse", clr_cnt - snap, 32'd0);
    step(); step(); step();                            // c14
    chk("to_c14_err", {31'd0, timeout_err_o}, 32'd1);
    timeout_clr_i = 1'b1;
    step();                                            // c15
    timeout_clr_i = 1'b0;
    chk("to_c15_err", {31'd0, timeout_err_o}, 32'd0);
    go_idle();

    // Ack arriving in the timeout-expiry cycle completes normally.
    present(1'b1, 3'b001, 4'd1);
    for (int c = 1; c <= 9; c++) step();               // c9
    irq_ack_i = 1'b1;
    step();                                            // c10
    irq_ack_i = 1'b0;
    chk("race_clr", {31'd0, clr_valid_o}, 32'd1);
    chk("race_err", {31'd0, timeout_err_o}, 32'd0);
    go_idle();

    // Frozen vector: channel changes while in REQ.
    present(1'b1, 3'b010, 4'd5);
    step(); step(); step();                            // c3
    present(1'b1, 3'b010, 4'd7);
    step();                                            // c4
    chk("frz_c4_chan", {28'd0, irq_chan_o}, 32'd5);
    irq_ack_i = 1'b1;
    step();                                            // c5
    irq_ack_i = 1'b0;
    chk("frz_c5_cch", {28'd0, clr_chan_o}, 32'd5);
    step(); step(); step(); step();                    // c9
    chk("frz_c9_irq",  {31'd0, irq_o}, 32'd1);
    chk("frz_c9_chan", {28'd0, irq_chan_o}, 32'd7);
    go_idle();

    // Reset in the middle of the handshake.
    present(1'b1, 3'b010, 4'd6);
    step(); step();                                    // c2
    chk("rmid_c2_irq", {31'd0, irq_o}, 32'd1);
    step();                                            // c3
    rst = 1'b1;
    step();                                            // c4
    rst = 1'b0;
    irq_ack_i = 1'b1;
    snap = clr_cnt;
    chk("rmid_c4_irq",  {31'd0, irq_o}, 32'd0);
    chk("rmid_c4_busy", {31'd0, busy_o}, 32'd0);
    chk("rmid_c4_chan", {28'd0, irq_chan_o}, 32'd0);
    chk("rmid_c4_lvl",  {30'd0, irq_level_o}, 32'd0);
    chk("rmid_c4_clr",  {31'd0, clr_valid_o}, 32'd0);
    step();                                            // c5
    irq_ack_i = 1'b0;
    chk("rmid_c5_irq",    {31'd0, irq_o}, 32'd0);
    chk("rmid_c5_busy",   {31'd0, busy_o}, 32'd0);
    chk("rmid_no_clr",    clr_cnt - snap, 32'd0);
    go_idle();

`ifdef IRQ_DISPATCH_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("svc_rst", {26'd0, svc_cnt_o}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      present(1'b1, 3'b010, 4'd1);
      step();
      go_idle();
    end
    chk("svc_a", {30'd0, svc_cnt_o[1:0]}, 32'd0);
    chk("svc_b", {30'd0, svc_cnt_o[3:2]}, 32'd3);
    chk("svc_c", {30'd0, svc_cnt_o[5:4]}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_dispatch_seq.md
Name: irq_dispatch_seq

Overview:
- Sequential dispatch stage directly downstream of the 9-channel / 3-level combinational interrupt priority encoder.
- Registers the encoder result (any-request flag, level flags, channel code) and presents one winning interrupt to the CPU with a level/channel vector.
- Holds the vector stable through an irq/ack handshake, then issues a one-cycle clear back to request capture.
- Enforces a settle hold-off before re-arbitrating; ack-timeout detection is included.

Parameters:
- CHAN_W, 4, width of channel code (9 channels: codes 0..8)
- HOLDOFF, 2, settle cycles after clear or timeout before re-sampling (0 = none)
- TIMEOUT, 8, max cycles irq_o is held without ack (0 = timeout disabled)
- CNT_W, 16, width of each service counter (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pe_any_i  in  1  encoder: at least one enabled request pending
- pe_level_i  in  3  encoder level flags; bit0 = level A (highest), bit1 = B, bit2 = C
- pe_chan_i  in  CHAN_W  encoder winning channel code
- irq_o  out  1  interrupt request to CPU
- irq_level_o  out  2  latched level: 0 = A, 1 = B, 2 = C
- irq_chan_o  out  CHAN_W  latched channel
- irq_ack_i  in  1  CPU acknowledge
- clr_valid_o  out  1  one-cycle clear strobe to request capture
- clr_level_o  out  2  level being cleared
- clr_chan_o  out  CHAN_W  channel being cleared
- busy_o  out  1  FSM not in IDLE
- timeout_err_o  out  1  sticky ack-timeout flag
- timeout_clr_i  in  1  clears timeout_err_o

Behaviour:
- Input stage: pe_* registered every cycle. Level encode: 0 if bit0; else 1 if bit1; else 2, including the case any=1 with no flag set.
- States: IDLE, REQ, CLR, SETTLE.
- IDLE:
  - Registered any=1 -> REQ. The vector is latched on the same edge.
  - irq_o rises 2 cycles after the encoder output is presented.
- REQ:
  - irq_o=1; vector frozen; input changes are ignored.
  - irq_ack_i=1 -> CLR.
  - TIMEOUT cycles of irq_o without ack -> SETTLE, set timeout_err_o, no clear issued.
  - Ack in the same cycle as timeout expiry: ack wins.
- CLR:
  - irq_o=0; clr_valid_o=1 for exactly one cycle, with clr_level_o/clr_chan_o equal to the latched vector.
  - Next state -> SETTLE, or -> IDLE if HOLDOFF=0.
- SETTLE: count HOLDOFF cycles -> IDLE. Ack here is ignored.
- irq_ack_i outside REQ is ignored.
- timeout_err_o:
  - timeout_clr_i clears it.
  - A set event in the same cycle as timeout_clr_i: set wins.
- busy_o = (state != IDLE).
- Reset:
  - All outputs 0, state IDLE, input register 0, timer 0, error flag cleared.
  - Reset mid-handshake drops irq_o with no clear strobe.
- Timer: single down-counter shared by REQ (timeout) and SETTLE (hold-off). Reloaded on each state entry; width $clog2(max(HOLDOFF,TIMEOUT)+1).

Optional Feature:
- Macro: IRQ_DISPATCH_STATS_EN.
- With the macro:
  - Extra output svc_cnt_o, out, 3*CNT_W: per-level saturating counters of completed (acked) services. Level A occupies the LSBs.
  - Counters increment on entry to CLR; cleared by rst; hold at all-ones when saturated.
- Without the macro: port and logic absent; all other behaviour identical.

Decomposition:
- Package irq_pkg:
  - state enum (IDLE, REQ, CLR, SETTLE)
  - level constants LVL_A=0, LVL_B=1, LVL_C=2
  - NUM_LEVELS=3, NUM_CHAN=9
- One sub-module, irq_cycle_timer: loadable down-counter with zero flag, parameterised width.

Test Plan:
- Basic service (HOLDOFF=2, TIMEOUT=8): any=1, level=3'b010, chan=5 at cycle 0; ack at cycle 4.
  - irq_o=1 in cycles 2-4 with level=1, chan=5.
  - Cycle 5: irq_o=0, clr_valid_o=1, level 1, chan 5.
  - busy_o=0 at cycle 8.
- Level decode: level=3'b111, chan=2 -> irq_level_o=0. level=3'b000 with any=1 -> irq_level_o=2.
- Timeout: request held, no ack.
  - irq_o high cycles 2-9.
  - Cycle 10: irq_o=0, timeout_err_o=1, no clr_valid_o pulse.
  - timeout_clr_i at cycle 14 -> flag 0 at cycle 15.
- Frozen vector: chan changes 5->7 while in REQ -> irq_chan_o stays 5. After settle, the new request (chan 7) is presented.
- Reset mid-operation: rst at cycle 3 of REQ -> cycle 4 all outputs 0, state IDLE, no clr pulse. Ack at cycle 4 is ignored.
- With IRQ_DISPATCH_STATS_EN, CNT_W=2: four level-B services -> svc_cnt_o B field = 3 (saturated); A and C fields = 0.
